// File: rtl/subs_layer_iter.sv
// Iterative PRESENT substitution layer: LANES S-boxes applied per cycle over PASSES cycles.
// Optional inverse S-box for decryption, enabled by defining SUBS_INV_EN. BLOCK_W is 64 or 128.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | substituting LANES nibbles per cycle, cnt selects the nibble group
// DONE  | result held on out_data until out_ready
module subs_layer_iter #(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int NIBS   = BLOCK_W / 4;
  localparam int PASSES = NIBS / LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load, step;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

`ifdef SUBS_INV_EN
  logic mode_q;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Mode is captured with the block so later in_inv activity cannot corrupt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (load) begin
      mode_q <= in_inv;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-place update of the nibble group selected by cnt_q.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = in_data;
      cnt_d  = '0;
    end else if (step) begin
      for (int l = 0; l < LANES; l++) begin
`ifdef SUBS_INV_EN
        data_d[(int'(cnt_q) * LANES + l) * 4 +: 4] = mode_q
          ? sbox_inv(data_q[(int'(cnt_q) * LANES + l) * 4 +: 4])
          : sbox_fwd(data_q[(int'(cnt_q) * LANES + l) * 4 +: 4]);
`else
        data_d[(int'(cnt_q) * LANES + l) * 4 +: 4] =
          sbox_fwd(data_q[(int'(cnt_q) * LANES + l) * 4 +: 4]);
`endif
      end
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_subs_layer_iter.sv
// Bench for subs_layer_iter: block-level reference model checked every cycle, plus directed
// cases for backpressure, mid-block reset and the 128-bit lane extremes.
module tb_subs_layer_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_inv, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_data;

  logic         v128, inv128, or128;
  logic [127:0] d128;
  logic         ready_a, valid_a, busy_a, ready_b, valid_b, busy_b;
  logic [127:0] data_a, data_b;

  subs_layer_iter #(.BLOCK_W(64), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy));

  subs_layer_iter #(.BLOCK_W(128), .LANES(32)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(v128), .in_ready(ready_a),
    .in_data(d128), .in_inv(inv128), .out_valid(valid_a),
    .out_ready(or128), .out_data(data_a), .busy(busy_a));

  subs_layer_iter #(.BLOCK_W(128), .LANES(1)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(v128), .in_ready(ready_b),
    .in_data(d128), .in_inv(inv128), .out_valid(valid_b),
    .out_ready(or128), .out_data(data_b), .busy(busy_b));

  localparam logic [3:0] FWD_T [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] INV_T [0:15] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                         4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-block reference: each nibble looked up in the table chosen for the block.
  function automatic logic [127:0] subs_model(input logic [127:0] d, input logic inv, input int nn);
    logic [127:0] r;
    logic [3:0]   x;
    logic         use_inv;
`ifdef SUBS_INV_EN
    use_inv = inv;
`else
    use_inv = 1'b0 & inv;
`endif
    r = '0;
    for (int i = 0; i < nn; i++) begin
      x = d[i*4 +: 4];
      r[i*4 +: 4] = use_inv ? INV_T[x] : FWD_T[x];
    end
    return r;
  endfunction

  // Block-level model of the 64-bit instance: one block in flight, due PASSES edges after acceptance.
  int           edge_n = 0;
  bit           pend = 1'b0;
  logic [63:0]  pend_data;
  int           pend_due = 0;
  logic [127:0] mtmp;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (edge_n > pend_due && out_ready) pend = 1'b0;
    end else if (in_valid) begin
      pend      = 1'b1;
      mtmp      = subs_model({64'h0, in_data}, in_inv, 16);
      pend_data = mtmp[63:0];
      pend_due  = edge_n + 4;
    end
    #1;
    chk("in_ready", in_ready, !pend);
    chk("out_valid", out_valid, pend && (edge_n >= pend_due));
    chk("busy", busy, pend && (edge_n < pend_due));
    if (pend && edge_n >= pend_due) chk("out_data", out_data, pend_data);
    if (!rst_n) chk("rst_out_data", out_data, 128'h0);
  end

  task automatic send64(input logic [63:0] d, input logic inv, output logic [63:0] got, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(negedge clk);
    in_valid = 1'b0; in_inv = ~inv; in_data = {$urandom, $urandom};
    lat = -1; got = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid && lat < 0) begin
        lat = i;
        got = out_data;
      end
    end
  endtask

  task automatic run128(input logic [127:0] d, input logic inv);
    int lat_a, lat_b;
    logic [127:0] ga, gb, exp;
    exp = subs_model(d, inv, 32);
    @(negedge clk);
    v128 = 1'b1; d128 = d; inv128 = inv;
    @(negedge clk);
    v128 = 1'b0; inv128 = ~inv; d128 = {4{$urandom}};
    lat_a = -1; lat_b = -1; ga = '0; gb = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid_a && lat_a < 0) begin lat_a = i; ga = data_a; end
      if (valid_b && lat_b < 0) begin lat_b = i; gb = data_b; end
    end
    chk("lat_lanes32", lat_a, 1);
    chk("lat_lanes1", lat_b, 32);
    chk("data_lanes32", ga, exp);
    chk("data_lanes1", gb, exp);
  endtask

  logic [63:0] got;
  int          lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1; in_data = '0;
    v128 = 1'b0; inv128 = 1'b0; or128 = 1'b1; d128 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("pin_fwd_zero", subs_model(128'h0, 1'b0, 16), 128'hCCCC_CCCC_CCCC_CCCC);
    chk("pin_fwd_count", subs_model(128'h0123_4567_89AB_CDEF, 1'b0, 16), 128'hC56B_90AD_3EF8_4712);
    chk("pin_wide", subs_model({2{64'h0123_4567_89AB_CDEF}}, 1'b0, 32), {2{64'hC56B_90AD_3EF8_4712}});

    send64(64'h0, 1'b0, got, lat);
    chk("zero_data", got, 64'hCCCC_CCCC_CCCC_CCCC);
    chk("zero_latency", lat, 4);
    send64(64'h0123_4567_89AB_CDEF, 1'b0, got, lat);
    chk("count_data", got, 64'hC56B_90AD_3EF8_4712);
    send64(64'hC56B_90AD_3EF8_4712, 1'b1, got, lat);
`ifdef SUBS_INV_EN
    chk("inverse_data", got, 64'h0123_4567_89AB_CDEF);
`else
    chk("inverse_disabled_data", got, 64'h40A8_ECF7_B123_9D56);
`endif

    // Backpressure with a second block waiting upstream.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; in_inv = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
    chk("bp_valid_seen", out_valid, 1'b1);
    in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_data_held", out_data, 64'hC56B_90AD_3EF8_4712);
      chk("bp_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_busy", busy, 1'b0);
    @(negedge clk);
    chk("bp_accepted_busy", busy, 1'b1);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the second BUSY cycle.
    in_valid = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0; in_inv = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, got, lat);
    chk("after_rst_data", got, 64'h2222_2222_2222_2222);
    chk("after_rst_latency", lat, 4);

    run128({2{64'h0123_4567_89AB_CDEF}}, 1'b0);
    chk("wide_literal", data_a, {2{64'hC56B_90AD_3EF8_4712}});
    for (int k = 0; k < 3; k++) run128({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
